// File: rtl/wb_pwm_multi_if.sv
// Wishbone B4 pipelined bus bundle for wb_pwm_multi.
// Signals: wb_stb, wb_we, wb_adr, wb_dat_i (master->slave); wb_dat_o, wb_ack, wb_stall (slave->master).
interface wb_pwm_multi_if #(
    parameter int ADDR_WIDTH = 5
);
    logic                  wb_stb;
    logic                  wb_we;
    logic [ADDR_WIDTH-1:0] wb_adr;
    logic [31:0]           wb_dat_i;
    logic [31:0]           wb_dat_o;
    logic                  wb_ack;
    logic                  wb_stall;

    modport master (
        output wb_stb, wb_we, wb_adr, wb_dat_i,
        input  wb_dat_o, wb_ack, wb_stall
    );

    modport slave (
        input  wb_stb, wb_we, wb_adr, wb_dat_i,
        output wb_dat_o, wb_ack, wb_stall
    );
endinterface

// File: rtl/wb_pwm_multi.sv
// wb_pwm_multi: multi-channel PWM, shared prescaler and period counter, Wishbone slave.
// Ports: clk, rst (sync, active-high), wb (slave modport), pwm_out[CHANNELS-1:0].
module wb_pwm_multi #(
    parameter int CHANNELS       = 4,
    parameter int WIDTH          = 8,
    parameter int PRESCALE_WIDTH = 16,
    parameter int ADDR_WIDTH     = 5
) (
    input  logic                clk,
    input  logic                rst,
    wb_pwm_multi_if.slave       wb,
    output logic [CHANNELS-1:0] pwm_out
);
    logic                           en_q, en_d;
    logic [CHANNELS-1:0]            pol_q, pol_d;
    logic [PRESCALE_WIDTH-1:0]      psc_val_q, psc_val_d;
    logic [WIDTH-1:0]               top_sh_q, top_sh_d;
    logic [CHANNELS-1:0][WIDTH-1:0] duty_sh_q, duty_sh_d;
    logic [WIDTH-1:0]               top_act_q, top_act_d;
    logic [CHANNELS-1:0][WIDTH-1:0] duty_act_q, duty_act_d;
    logic [PRESCALE_WIDTH-1:0]      psc_q, psc_d;
    logic [WIDTH-1:0]               cnt_q, cnt_d;
    logic [CHANNELS-1:0]            pwm_q, pwm_d;
    logic                           ack_q, ack_d;
    logic [31:0]                    dat_o_q, dat_o_d;

    int unsigned adr;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] rdata;
    logic        tick;
    logic        wrap;
    logic        unused_dat;

    assign unused_dat = ^wb.wb_dat_i;

    // Register file: writes and read mux
    always_comb begin
        adr       = 32'(wb.wb_adr);
        wr_en     = wb.wb_stb && wb.wb_we;
        rd_en     = wb.wb_stb && !wb.wb_we;
        en_d      = en_q;
        pol_d     = pol_q;
        psc_val_d = psc_val_q;
        top_sh_d  = top_sh_q;
        duty_sh_d = duty_sh_q;
        rdata     = '0;

        if (wr_en) begin
            unique case (adr)
                32'd0: begin
                    en_d  = wb.wb_dat_i[0];
                    pol_d = wb.wb_dat_i[8 +: CHANNELS];
                end
                32'd1: psc_val_d = wb.wb_dat_i[PRESCALE_WIDTH-1:0];
                32'd2: top_sh_d = wb.wb_dat_i[WIDTH-1:0];
                default: begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (adr == 32'(4 + i)) begin
                            duty_sh_d[i] = wb.wb_dat_i[WIDTH-1:0];
                        end
                    end
                end
            endcase
        end

        unique case (adr)
            32'd0: begin
                rdata[0]            = en_q;
                rdata[8 +: CHANNELS] = pol_q;
            end
            32'd1: rdata[PRESCALE_WIDTH-1:0] = psc_val_q;
            32'd2: rdata[WIDTH-1:0] = top_sh_q;
            32'd3: rdata[WIDTH-1:0] = cnt_q;
            default: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (adr == 32'(4 + i)) begin
                        rdata[WIDTH-1:0] = duty_sh_q[i];
                    end
                end
            end
        endcase

        ack_d   = wb.wb_stb;
        dat_o_d = rd_en ? rdata : '0;
    end

    // Prescaler, period counter, shadow commit and outputs
    always_comb begin
        // >= so that lowering P below the running psc wraps on the next cycle
        tick       = en_q && (psc_q >= psc_val_q);
        wrap       = tick && (cnt_q >= top_act_q);
        psc_d      = psc_q;
        cnt_d      = cnt_q;
        top_act_d  = top_act_q;
        duty_act_d = duty_act_q;

        if (!en_q) begin
            psc_d      = '0;
            cnt_d      = '0;
            top_act_d  = top_sh_q;
            duty_act_d = duty_sh_q;
        end else begin
            psc_d = tick ? '0 : psc_q + PRESCALE_WIDTH'(1);
            if (tick) begin
                cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
            end
            // Uses the shadow value before this cycle's write, so a write
            // landing on the wrap cycle waits for the following wrap.
            if (wrap) begin
                top_act_d  = top_sh_q;
                duty_act_d = duty_sh_q;
            end
        end

        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = en_q ? ((duty_act_q[i] > cnt_q) ^ pol_q[i]) : pol_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q       <= 1'b0;
            pol_q      <= '0;
            psc_val_q  <= '0;
            top_sh_q   <= '0;
            duty_sh_q  <= '0;
            top_act_q  <= '0;
            duty_act_q <= '0;
            psc_q      <= '0;
            cnt_q      <= '0;
            pwm_q      <= '0;
            ack_q      <= 1'b0;
            dat_o_q    <= '0;
        end else begin
            en_q       <= en_d;
            pol_q      <= pol_d;
            psc_val_q  <= psc_val_d;
            top_sh_q   <= top_sh_d;
            duty_sh_q  <= duty_sh_d;
            top_act_q  <= top_act_d;
            duty_act_q <= duty_act_d;
            psc_q      <= psc_d;
            cnt_q      <= cnt_d;
            pwm_q      <= pwm_d;
            ack_q      <= ack_d;
            dat_o_q    <= dat_o_d;
        end
    end

    assign wb.wb_ack   = ack_q;
    assign wb.wb_dat_o = dat_o_q;
    assign wb.wb_stall = 1'b0;
    assign pwm_out     = pwm_q;
endmodule

// File: doc/wb_pwm_multi.md
Name: wb_pwm_multi

Overview:
- Multi-channel PWM peripheral with a Wishbone B4 pipelined slave port.
- CHANNELS outputs share one period counter and one prescaler.
- Per-channel duty registers are double-buffered and committed only at the period boundary, so updates never glitch.
- Successor to the single-channel 8-bit PWM: adds parametrised width, channel count, prescaler, programmable period, per-channel polarity and readback.

Parameters:
- CHANNELS, 4: number of PWM outputs (1..16).
- WIDTH, 8: counter, top and duty width in bits (1..16).
- PRESCALE_WIDTH, 16: prescaler register width.
- ADDR_WIDTH, 5: word address width; must satisfy 2^ADDR_WIDTH >= CHANNELS+4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wb_stb  in  1  request strobe (cyc implied)
- wb_we  in  1  1=write, 0=read
- wb_adr  in  ADDR_WIDTH  word address
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, valid when wb_ack=1
- wb_ack  out  1  one-cycle acknowledge
- wb_stall  out  1  tied 0
- pwm_out  out  CHANNELS  PWM outputs, bit i = channel i

Behaviour:
- Register map (word addresses). Narrower fields take the low bits of wb_dat_i; unused read bits return 0.
  - 0 CTRL: bit0 EN; bits[8+i] POL[i], 1 inverts channel i.
  - 1 PRESCALE: value P; one tick every P+1 clocks.
  - 2 TOP: shadow period value; counter runs 0..TOP inclusive.
  - 3 COUNT: read-only current counter value; writes ignored.
  - 4+i DUTY[i]: shadow duty for channel i.
  - Unmapped addresses: ack, read 0, write ignored.
- Bus timing:
  - Every cycle with wb_stb=1 is accepted (no stall).
  - wb_ack=1 exactly one cycle later; back-to-back requests give back-to-back acks.
  - Read data reflects the register value at the request cycle.
  - Write takes effect in the cycle after the request.
- Prescaler:
  - psc counts 0..P; tick asserted when psc==P, then psc wraps to 0.
  - P=0 gives a tick every clock.
  - A P write applies immediately; if psc > new P, the next cycle wraps psc to 0 and asserts tick.
- Counter:
  - On tick: if cnt==top_act, then cnt<=0 and wrap is asserted; otherwise cnt<=cnt+1.
- Commit:
  - On a wrap cycle, top_act<=TOP shadow and duty_act[i]<=DUTY[i] shadow.
  - A shadow write in the same cycle as wrap is not committed; it commits at the next wrap.
- Output:
  - Raw output r[i] = (duty_act[i] > cnt).
  - duty_act=0 gives constant low.
  - duty_act > top_act gives constant high.
  - duty_act == top_act gives high for top_act of top_act+1 counts.
  - pwm_out[i] = r[i] XOR POL[i], registered, so 1 clk latency from cnt.
- Disabled (EN=0):
  - psc and cnt held at 0.
  - Shadows copy to active every cycle.
  - pwm_out[i] = POL[i].
  - On 0->1 the count starts at 0 using the latest shadows.
- Reset:
  - Clears all registers, shadows, actives, psc, cnt, wb_ack and wb_dat_o to 0, so pwm_out=0.
  - Reset mid-transfer drops the pending ack.
  - Reset has priority over every other event.

Test Plan:
- Reset, then read all addresses 0..CHANNELS+3 -> all 0, acks one cycle after each stb, pwm_out=0.
- P=0, TOP=9, DUTY0=3, EN=1 -> ch0 high 3 clks, low 7 clks, period 10 clks; COUNT readback cycles 0..9.
- P=2, TOP=3, DUTY1=2 -> ticks every 3 clks; ch1 high 6 clks of 12.
- DUTY0=0 -> ch0 constant 0. DUTY0=10 with TOP=9 -> ch0 constant 1. Set POL0=1 -> both levels invert.
- Running TOP=9, DUTY0=3; write DUTY0=7 mid-period -> current period still 3 high; next period 7 high. Repeat with the write landing in the wrap cycle -> change delayed one extra period.
- Back-to-back stb on 4 consecutive cycles (write, read, write to unmapped address, read) -> 4 consecutive acks, wb_stall=0. Assert rst during this burst -> no further acks, everything returns to 0.
